// File: rtl/mux_4_1_rr_arbiter.sv
// mux_4_1_rr_arbiter
// Four-requester registered multiplexer with a round-robin arbiter that lets
// one requester hold the output for up to MAX_BURST consecutive words.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-requester valid (bit i = requester i)
//   d0..d3     per-requester data, W bits each
//   in_ready   per-requester ready, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered selected word
//   out_id     index of the requester that supplied out_data
//   out_ready  downstream accepts the held word this cycle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; next search starts at r_rr_ptr
// ST_OWNED | r_owner valid; owner may continue until burst limit is hit
module mux_4_1_rr_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_id,
  input  logic         out_ready
);

  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t       r_state;
  logic [1:0]   r_owner;
  logic [1:0]   r_rr_ptr;
  logic [3:0]   r_burst_cnt;

  logic         w_slot_free;
  logic         w_grant;
  logic         w_keep_owner;
  logic [1:0]   w_start;
  logic [1:0]   w_idx;
  logic [1:0]   w_winner;
  logic         w_found;
  logic [1:0]   w_sel;
  logic [W-1:0] w_sel_data;

  always_comb begin
    w_slot_free  = ~out_valid | out_ready;
    w_grant      = w_slot_free & (|in_valid);
    w_keep_owner = (r_state == ST_OWNED) && in_valid[r_owner] &&
                   (r_burst_cnt < LP_MAX_BURST);
    // A fresh search in OWNED starts just past the owner, so an owner that is
    // the only requester still wins (wrapping around) with a restarted burst.
    w_start      = (r_state == ST_OWNED) ? r_owner + 2'd1 : r_rr_ptr;
    w_idx        = 2'd0;
    w_winner     = w_start;
    w_found      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + 2'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
    w_sel    = w_keep_owner ? r_owner : w_winner;
    in_ready = w_grant ? (4'b0001 << w_sel) : 4'b0000;
  end

  always_comb begin
    case (w_sel)
      2'd0:    w_sel_data = d0;
      2'd1:    w_sel_data = d1;
      2'd2:    w_sel_data = d2;
      default: w_sel_data = d3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 2'd0;
      r_burst_cnt <= 4'd0;
      r_rr_ptr    <= 2'd0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= 2'd0;
    end else if (w_grant) begin
      out_valid <= 1'b1;
      out_data  <= w_sel_data;
      out_id    <= w_sel;
      if (w_keep_owner) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end else begin
        r_state     <= ST_OWNED;
        r_owner     <= w_winner;
        r_burst_cnt <= 4'd1;
        r_rr_ptr    <= w_winner + 2'd1;
      end
    end else begin
      if (out_ready) out_valid <= 1'b0;
      // Nobody asking while the slot is free: drop ownership.
      if (w_slot_free && (r_state == ST_OWNED)) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= r_owner + 2'd1;
      end
    end
  end

endmodule
